// File: rtl/mdu_iterative.sv
// ============================================================================
// mdu_iterative: shared radix-2 shift-add multiplier / restoring divider.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mdu_iterative #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             n_flag,
    output logic             z_flag,
    output logic             dz
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam int             CW     = $clog2(WIDTH);
    localparam logic [CW-1:0]  C_LAST = CW'(WIDTH - 1);
    localparam logic [2:0]     C_MUL   = 3'b000;
    localparam logic [2:0]     C_UMULL = 3'b001;
    localparam logic [2:0]     C_SMULL = 3'b010;
    localparam logic [2:0]     C_UDIV  = 3'b100;
    localparam logic [2:0]     C_SDIV  = 3'b101;

    state_t             r_state, w_next;
    logic [CW-1:0]      r_cnt;
    logic [2:0]         r_op;
    logic               r_sign_q, r_sign_r;
    logic [2*WIDTH-1:0] r_acc;    // product, or {unused, dividend/quotient}
    logic [WIDTH:0]     r_rem;
    logic [WIDTH-1:0]   r_opb;

    logic               w_in_signed, w_a_neg, w_b_neg;
    logic [WIDTH-1:0]   w_a_mag, w_b_mag;
    logic               w_is_mul, w_is_div, w_is_long, w_dz;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH+1:0]   w_shift;
    logic [WIDTH:0]     w_diff;
    logic               w_fits;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_res_lo, w_res_hi;

    assign w_in_signed = (op == C_SMULL) || (op == C_SDIV);
    assign w_a_neg     = w_in_signed && a[WIDTH-1];
    assign w_b_neg     = w_in_signed && b[WIDTH-1];
    assign w_a_mag     = w_a_neg ? -a : a;
    assign w_b_mag     = w_b_neg ? -b : b;

    assign w_is_mul  = (r_op == C_MUL) || (r_op == C_UMULL) || (r_op == C_SMULL);
    assign w_is_div  = (r_op == C_UDIV) || (r_op == C_SDIV);
    assign w_is_long = (r_op == C_UMULL) || (r_op == C_SMULL);
    assign w_dz      = w_is_div && (r_opb == '0);

    assign w_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_opb};
    assign w_shift = {r_rem, r_acc[WIDTH-1]};
    assign w_fits  = w_shift >= {2'b00, r_opb};
    assign w_diff  = w_shift[WIDTH:0] - {1'b0, r_opb};
    assign w_prod  = r_sign_q ? -r_acc : r_acc;

    always_comb begin
        w_res_lo = '0;
        w_res_hi = '0;
        if (w_is_mul) begin
            w_res_lo = w_prod[WIDTH-1:0];
            w_res_hi = w_prod[2*WIDTH-1:WIDTH];
        end else if (w_dz) begin
            // Dividend magnitude is left untouched in r_acc; restore its sign.
            w_res_hi = r_sign_r ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
        end else if (w_is_div) begin
            w_res_lo = r_sign_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
            w_res_hi = r_sign_r ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (start) w_next = S_CALC;
            S_CALC: if (r_cnt == C_LAST) w_next = S_FIX;
            S_FIX:  w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (flush) w_next = S_IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt     <= '0;
            r_op      <= '0;
            r_sign_q  <= 1'b0;
            r_sign_r  <= 1'b0;
            r_acc     <= '0;
            r_rem     <= '0;
            r_opb     <= '0;
            result_lo <= '0;
            result_hi <= '0;
            n_flag    <= 1'b0;
            z_flag    <= 1'b0;
            dz        <= 1'b0;
        end else if (flush) begin
            r_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    r_op     <= op;
                    r_sign_q <= w_a_neg ^ w_b_neg;
                    r_sign_r <= w_a_neg;
                    r_acc    <= {{WIDTH{1'b0}}, w_a_mag};
                    r_rem    <= '0;
                    r_opb    <= w_b_mag;
                    r_cnt    <= '0;
                end
                S_CALC: begin
                    r_cnt <= (r_cnt == C_LAST) ? '0 : r_cnt + CW'(1);
                    if (w_is_mul) begin
                        r_acc <= r_acc[0] ? {w_sum, r_acc[WIDTH-1:1]}
                                          : {1'b0, r_acc[2*WIDTH-1:1]};
                    end else if (w_is_div && !w_dz) begin
                        r_rem <= w_fits ? w_diff : w_shift[WIDTH:0];
                        r_acc <= {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-2:0], w_fits};
                    end
                end
                S_FIX: begin
                    result_lo <= w_res_lo;
                    result_hi <= w_res_hi;
                    dz        <= w_dz;
                    n_flag    <= w_is_long ? w_res_hi[WIDTH-1] : w_res_lo[WIDTH-1];
                    z_flag    <= w_is_long ? ({w_res_hi, w_res_lo} == '0)
                                           : (w_res_lo == '0);
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = (r_state == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_mdu_iterative.sv
// Testbench for mdu_iterative: directed ops with a scoreboard of model results.
`default_nettype none

module tb_mdu_iterative;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset, start, flush;
    logic [2:0]   op;
    logic [W-1:0] a, b;
    logic         busy, done, n_flag, z_flag, dz;
    logic [W-1:0] result_lo, result_hi;

    mdu_iterative #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .busy(busy), .done(done), .result_lo(result_lo),
        .result_hi(result_hi), .n_flag(n_flag), .z_flag(z_flag), .dz(dz)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         n;
        logic         z;
        logic         dz;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   t0      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t          e;
        logic [2*W-1:0] p;
        longint        sx, sy, q, r;
        logic          is_long;
        e  = '0;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            3'd0, 3'd1: begin
                p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
                e.lo = p[W-1:0]; e.hi = p[2*W-1:W];
            end
            3'd2: begin
                p = sx * sy;
                e.lo = p[W-1:0]; e.hi = p[2*W-1:W];
            end
            3'd4: begin
                if (y == '0) begin e.hi = x; e.dz = 1'b1; end
                else begin e.lo = x / y; e.hi = x % y; end
            end
            3'd5: begin
                if (y == '0) begin e.hi = x; e.dz = 1'b1; end
                else begin
                    q = sx / sy; r = sx % sy;
                    e.lo = q[W-1:0]; e.hi = r[W-1:0];
                end
            end
            default: ;
        endcase
        is_long = (o == 3'd1) || (o == 3'd2);
        e.n = is_long ? e.hi[W-1] : e.lo[W-1];
        e.z = is_long ? ({e.hi, e.lo} == '0) : (e.lo == '0);
        return e;
    endfunction

    // Operands are scrambled after launch; the result must not depend on them.
    task automatic launch(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        t0 = cyc;
        sb.push_back(model(o, x, y));
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom; op = 3'($urandom);
    endtask

    task automatic wait_done(input string tag);
        exp_t e;
        while (!done && (cyc - t0) < W + 10) @(negedge clk);
        chk({tag, " latency"}, 64'(cyc - t0), 64'(W + 2));
        if (done) begin
            if (sb.size() == 0) begin
                chk({tag, " unexpected done"}, 64'(1), 64'(0));
            end else begin
                e = sb.pop_front();
                chk({tag, " result"}, {result_hi, result_lo}, {e.hi, e.lo});
                chk({tag, " flags n/z/dz"}, {n_flag, z_flag, dz}, {e.n, e.z, e.dz});
            end
            @(negedge clk);
            chk({tag, " done/busy after"}, {done, busy}, 2'b00);
        end
    endtask

    initial begin
        logic saw_done;
        reset = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        chk("reset outputs", {busy, done, n_flag, z_flag, dz, result_lo, result_hi},
            {5'b0, {2*W{1'b0}}});
        reset = 1'b0;

        // 1: SMULL -3 * 5
        launch(3'b010, 32'hFFFFFFFD, 32'h00000005);
        chk("smull busy", busy, 1'b1);
        wait_done("smull");
        // 2: UDIV and UMULL
        launch(3'b100, 32'd100, 32'd7);
        wait_done("udiv");
        launch(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done("umull");
        // 3: SDIV negative dividend and MIN / -1
        launch(3'b101, 32'hFFFFFFF9, 32'd2);
        wait_done("sdiv neg");
        launch(3'b101, 32'h80000000, 32'hFFFFFFFF);
        wait_done("sdiv min");
        // 4: divide by zero, then zero product
        launch(3'b100, 32'd5, 32'd0);
        wait_done("udiv dz");
        launch(3'b101, 32'hFFFFFFF0, 32'd0);
        wait_done("sdiv dz");
        launch(3'b000, 32'd0, 32'd0);
        wait_done("mul zero");
        launch(3'b111, 32'h1234, 32'h5678);
        wait_done("reserved");

        // 5: start while busy is ignored; flush discards in-flight op
        launch(3'b000, 32'd3, 32'd4);
        repeat (8) @(negedge clk);
        start = 1'b1; op = 3'b100; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        wait_done("mul busy-start");
        chk("no queued op", 64'(sb.size()), 64'(0));
        @(negedge clk);
        start = 1'b1; op = 3'b000; a = 32'd5; b = 32'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (18) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush busy", busy, 1'b0);
        saw_done = 1'b0;
        repeat (40) begin @(negedge clk); saw_done |= done; end
        chk("flush no done", saw_done, 1'b0);
        chk("flush result kept", result_lo, 32'd12);

        // 6: asynchronous reset mid-operation
        launch(3'b010, 32'hFFFFFFFD, 32'h00000005);
        repeat (13) @(negedge clk);
        #2 reset = 1'b1;
        #1 chk("async reset outputs", {busy, done, n_flag, z_flag, dz, result_lo, result_hi},
               {5'b0, {2*W{1'b0}}});
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        saw_done = 1'b0;
        repeat (40) begin @(negedge clk); saw_done |= done; end
        chk("post-reset no done", saw_done, 1'b0);
        launch(3'b000, 32'd6, 32'd7);
        wait_done("mul after reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/mdu_iterative.md
Name: mdu_iterative

Overview:
Iterative multiply/divide unit for the multicycle ARM core. It replaces the single-cycle 64-bit multiply path in the ALU with a shared shift-add multiplier and restoring divider. The unit supports MUL, UMULL, SMULL, UDIV and SDIV and is parametrised in operand width. The controller launches an operation with a start pulse, stalls on busy, and writes back the low and high results on done through the 32b/64b register-file write ports.

Parameters:
WIDTH, 32, operand width in bits; products are 2*WIDTH bits; must be at least 4.

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  asynchronous, active-high; returns the unit to IDLE
start  input  1  launch request; sampled only in IDLE
op  input  3  000 MUL, 001 UMULL, 010 SMULL, 100 UDIV, 101 SDIV; other codes reserved
a  input  WIDTH  multiplicand or dividend (RA1 operand)
b  input  WIDTH  multiplier or divisor (RA2 operand)
flush  input  1  synchronous abort
busy  output  1  high whenever state is not IDLE
done  output  1  single-cycle completion strobe
result_lo  output  WIDTH  product[W-1:0] or quotient
result_hi  output  WIDTH  product[2W-1:W] or remainder
n_flag  output  1  negative flag of the result
z_flag  output  1  zero flag of the result
dz  output  1  divide-by-zero indicator

Behaviour:
- Reset (async): state=IDLE; busy, done, dz, n_flag, z_flag = 0; result_lo, result_hi = 0; iteration counter = 0.
- States are IDLE, CALC, FIX and DONE.
- IDLE, edge E0 with start=1: latch op. Latch |a| and |b| (magnitudes for SMULL/SDIV, raw values otherwise). Record the result sign: a^b for the product/quotient; a's sign for the remainder. Go to CALC. With start=0, stay in IDLE.
- CALC: one step per cycle for exactly WIDTH cycles (edges E1..E_W). Counter wraps from WIDTH-1 to 0, then go to FIX.
  - Multiply: radix-2 shift-add into a 2W accumulator.
  - Divide: restoring shift-subtract; remainder register is W+1 bits.
- FIX, edge E_{W+1}: apply two's-complement negation per recorded signs. Write result_lo, result_hi, flags and dz. Go to DONE.
- DONE: done=1 for exactly this one cycle. Next edge goes to IDLE.
- Latency: done is high in the cycle after edge E0+W+1 (33 edges for W=32). Latency is fixed for every op, including divide-by-zero and reserved codes.
- busy=1 in CALC, FIX and DONE. A start seen while busy is ignored, with no queuing. A new start is accepted on the edge after DONE.
- Result registers hold their value until the next FIX write. They are unaffected by flush.
- MUL: result_lo = low W bits of the unsigned product; result_hi = high W bits of the unsigned product.
- UMULL/SMULL: full 2W product across {result_hi, result_lo}.
- UDIV/SDIV:
  - result_lo = quotient, truncated toward zero.
  - result_hi = remainder, carrying the sign of the dividend.
  - SDIV MIN/-1 yields quotient = MIN (wrap) and remainder = 0; no trap.
- Divide by zero (b=0, UDIV/SDIV): result_lo = 0, result_hi = a unmodified, dz=1. Latency is unchanged. dz=0 for every other completion.
- Reserved op: result_lo = result_hi = 0, dz=0, normal completion.
- Flags, all ops:
  - Long ops (001, 010): n_flag = result_hi[W-1]; z_flag = ({result_hi, result_lo} == 0).
  - All other ops: n_flag = result_lo[W-1]; z_flag = (result_lo == 0).
- flush=1 on any edge: next state is IDLE and counter is cleared. Any in-flight op is discarded with no done and no result write. flush has priority over start. flush in DONE suppresses nothing already emitted, but forces IDLE.
- Reset mid-operation: immediate IDLE with all outputs zeroed. done must not appear afterwards without a new start.
- Operands a and b may change after E0 without affecting the result.

Test Plan:
1. W=32, SMULL a=FFFFFFFD (-3), b=00000005 -> after 33 edges: done=1 for one cycle; result_hi=FFFFFFFF, result_lo=FFFFFFF1; n_flag=1, z_flag=0; busy drops the edge after done.
2. UDIV a=100, b=7 -> result_lo=14, result_hi=2, dz=0. Then UMULL a=FFFFFFFF, b=FFFFFFFF -> result_hi=FFFFFFFE, result_lo=00000001.
3. SDIV a=FFFFFFF9 (-7), b=2 -> result_lo=FFFFFFFD, result_hi=FFFFFFFF. Then SDIV a=80000000, b=FFFFFFFF -> result_lo=80000000, result_hi=0, n_flag=1.
4. UDIV a=5, b=0 -> done at the same 33-edge latency; result_lo=0, result_hi=5, dz=1, z_flag=1. A following MUL 0x0 -> z_flag=1, dz=0.
5. Start MUL 3x4, assert start with op=UDIV at cycle 10 -> second start is ignored; result_lo=12. flush at cycle 20 of a second op -> busy=0 next cycle, no done, result_lo still 12.
6. Assert reset at cycle 15 of SMULL -> all outputs 0 immediately. Release reset and idle 40 cycles -> done never rises. A new MUL 6x7 -> result_lo=42.
